// File: rtl/arr_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exm_arr_stim_pkg
// Purpose : Shared types and constants for the arr stimulus source: the FSM
//           state encoding, the LFSR polynomial and width, the counter width,
//           and the LFSR next-state helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package exm_arr_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          LFSR_W_C    = 32;
  localparam logic [31:0] LFSR_POLY_C = 32'h80200003;
  localparam int          CNT_W_C     = 32;

  // Galois LFSR, right shift: the bit shifted out selects the polynomial tap.
  function automatic logic [LFSR_W_C-1:0] lfsr_next(input logic [LFSR_W_C-1:0] l);
    return {1'b0, l[LFSR_W_C-1:1]} ^ (l[0] ? LFSR_POLY_C : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arr_stim_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : arr_stim_lfsr
// Purpose : 32-bit Galois LFSR state register for arr_stim. load has priority
//           over advance; with neither asserted the state holds.
// Ports   : clk      in  1   clock
//           rst_n    in  1   asynchronous active-low reset (state <- RESET_VAL)
//           load     in  1   reload state from seed
//           seed     in  32  reload value
//           advance  in  1   step the LFSR once
//           value    out 32  current LFSR state
// Revision: 1.0 - initial release
// ============================================================================
module arr_stim_lfsr
  import exm_arr_stim_pkg::*;
#(
  parameter logic [LFSR_W_C-1:0] RESET_VAL = 32'h1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [LFSR_W_C-1:0] seed,
  input  logic                advance,
  output logic [LFSR_W_C-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule
`default_nettype wire

// File: rtl/arr_stim.sv
`default_nettype none
// ============================================================================
// Module  : arr_stim
// Purpose : Stimulus source for the arr comparator array. After a start pulse
//           and WARMUP idle cycles it drives CYCLES pseudo-random matched
//           vectors on sig0/sig1 from an LFSR, then flags done.
//           Optional feature macro: EXM_ARR_STIM_INJECT_EN - when defined and
//           ERR_PERIOD != 0, every ERR_PERIOD-th vector has sig1 bit0 flipped.
// Ports   : arr_stim_clk_ip      in  1       clock
//           arr_stim_rst_n_ip    in  1       asynchronous active-low reset
//           arr_stim_start_ip    in  1       start pulse (IDLE/DONE only)
//           arr_stim_hold_ip     in  1       stall; state/counters/LFSR frozen
//           arr_stim_sig0_op     out LENGTH  reference vector
//           arr_stim_sig1_op     out LENGTH  compare vector
//           arr_stim_valid_op    out 1       vector presented this cycle
//           arr_stim_busy_op     out 1       in WAIT or DRIVE
//           arr_stim_done_op     out 1       in DONE
//           arr_stim_vec_cnt_op  out 32      vectors presented this run
//           arr_stim_inj_cnt_op  out 32      injected vectors this run
// Revision: 1.0 - initial release
// ============================================================================
module arr_stim
  import exm_arr_stim_pkg::*;
#(
  parameter int unsigned LENGTH     = 8,
  parameter int unsigned CYCLES     = 1000,
  parameter int unsigned WARMUP     = 4,
  parameter logic [31:0] SEED       = 32'h1,
  parameter int unsigned ERR_PERIOD = 16
) (
  input  logic               arr_stim_clk_ip,
  input  logic               arr_stim_rst_n_ip,
  input  logic               arr_stim_start_ip,
  input  logic               arr_stim_hold_ip,
  output logic [LENGTH-1:0]  arr_stim_sig0_op,
  output logic [LENGTH-1:0]  arr_stim_sig1_op,
  output logic               arr_stim_valid_op,
  output logic               arr_stim_busy_op,
  output logic               arr_stim_done_op,
  output logic [CNT_W_C-1:0] arr_stim_vec_cnt_op,
  output logic [CNT_W_C-1:0] arr_stim_inj_cnt_op
);

  localparam logic [CNT_W_C-1:0] CYCLES_C     = CNT_W_C'(CYCLES);
  localparam logic [CNT_W_C-1:0] WARMUP_C     = CNT_W_C'(WARMUP);
  localparam logic [CNT_W_C-1:0] ERR_PERIOD_C = CNT_W_C'(ERR_PERIOD);

`ifdef EXM_ARR_STIM_INJECT_EN
  localparam bit INJ_EN_C = (ERR_PERIOD != 0);
`else
  // ERR_PERIOD stays in the expression so both builds share one parameter list.
  localparam bit INJ_EN_C = 1'b0 && (ERR_PERIOD != 0);
`endif

  state_t                state;
  state_t                next_state;
  logic [CNT_W_C-1:0]    warm_cnt;
  logic [CNT_W_C-1:0]    vec_cnt_inc;
  logic [LFSR_W_C-1:0]   lfsr_val;
  logic [LFSR_W_C-1:0]   lfsr_nxt;
  logic [LENGTH-1:0]     vec;
  logic                  start_acc;
  logic                  warm_done;
  logic                  present;
  logic                  inject;
  logic                  unused_lfsr_bits;

  // start is only honoured from a resting state; it beats hold there.
  assign start_acc = arr_stim_start_ip && ((state == IDLE) || (state == DONE));

  // WARMUP==0 still spends one cycle in WAIT.
  assign warm_done = (WARMUP_C == '0) || (warm_cnt == (WARMUP_C - 1'b1));

  // A vector is issued on every unheld DRIVE edge until the run length is
  // reached; the following edge moves to DONE.
  assign present = (state == DRIVE) && !arr_stim_hold_ip && (arr_stim_vec_cnt_op < CYCLES_C);

  assign vec_cnt_inc = (arr_stim_vec_cnt_op == '1) ? arr_stim_vec_cnt_op
                                                   : arr_stim_vec_cnt_op + 1'b1;

  // The presented vector is taken from the freshly advanced LFSR state.
  assign lfsr_nxt = lfsr_next(lfsr_val);

  // Replicate the 32-bit state as often as needed, truncated to LENGTH.
  for (genvar i = 0; i < LENGTH; i++) begin : g_rep
    assign vec[i] = lfsr_nxt[i % LFSR_W_C];
  end

  // Upper LFSR bits are not presented when LENGTH < 32.
  assign unused_lfsr_bits = ^lfsr_nxt;

  if (INJ_EN_C) begin : g_inj
    assign inject = present && ((vec_cnt_inc % ERR_PERIOD_C) == '0);
  end else begin : g_no_inj
    assign inject = 1'b0;
  end

  arr_stim_lfsr #(
    .RESET_VAL (SEED)
  ) u_lfsr (
    .clk     (arr_stim_clk_ip),
    .rst_n   (arr_stim_rst_n_ip),
    .load    (start_acc),
    .seed    (SEED),
    .advance (present),
    .value   (lfsr_val)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge arr_stim_clk_ip or negedge arr_stim_rst_n_ip) begin
    if (!arr_stim_rst_n_ip) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (hold freezes WAIT and DRIVE)
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: begin
        if (arr_stim_start_ip) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (!arr_stim_hold_ip && warm_done) begin
          next_state = (CYCLES_C == '0) ? DONE : DRIVE;
        end
      end
      DRIVE: begin
        if (!arr_stim_hold_ip && (arr_stim_vec_cnt_op >= CYCLES_C)) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    arr_stim_busy_op = 1'b0;
    arr_stim_done_op = 1'b0;
    unique case (state)
      WAIT, DRIVE: arr_stim_busy_op = 1'b1;
      DONE:        arr_stim_done_op = 1'b1;
      default:     ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: warm-up counter, vector registers, run counters
  // --------------------------------------------------------------------------
  always_ff @(posedge arr_stim_clk_ip or negedge arr_stim_rst_n_ip) begin
    if (!arr_stim_rst_n_ip) begin
      warm_cnt            <= '0;
      arr_stim_sig0_op    <= '0;
      arr_stim_sig1_op    <= '0;
      arr_stim_valid_op   <= 1'b0;
      arr_stim_vec_cnt_op <= '0;
      arr_stim_inj_cnt_op <= '0;
    end else begin
      arr_stim_valid_op <= present;

      if (start_acc) begin
        warm_cnt            <= '0;
        arr_stim_vec_cnt_op <= '0;
        arr_stim_inj_cnt_op <= '0;
      end else if ((state == WAIT) && !arr_stim_hold_ip) begin
        warm_cnt <= warm_cnt + 1'b1;
      end

      if (present) begin
        arr_stim_sig0_op    <= vec;
        arr_stim_sig1_op    <= {vec[LENGTH-1:1], vec[0] ^ inject};
        arr_stim_vec_cnt_op <= vec_cnt_inc;
        if (inject && (arr_stim_inj_cnt_op != '1)) begin
          arr_stim_inj_cnt_op <= arr_stim_inj_cnt_op + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arr_stim.sv
`default_nettype none
// ============================================================================
// Module  : tb_arr_stim
// Purpose : Self-checking bench for arr_stim. Expected vectors come from an
//           independent LFSR model and are queued at start; each valid cycle
//           pops one entry. A second instance runs with CYCLES=0.
// Revision: 1.0 - initial release
// ============================================================================
module tb_arr_stim;

  localparam int unsigned LEN  = 8;
  localparam int unsigned CYC  = 10;
  localparam int unsigned WARM = 4;
  localparam int unsigned EP   = 4;
  localparam logic [31:0] SEED_V = 32'h1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            hold = 1'b0;
  logic [LEN-1:0]  sig0, sig1, sig0_z, sig1_z;
  logic            valid, busy, done, valid_z, busy_z, done_z;
  logic [31:0]     vec_cnt, inj_cnt, vec_cnt_z, inj_cnt_z;

  always #5 clk = ~clk;

  arr_stim #(.LENGTH(LEN), .CYCLES(CYC), .WARMUP(WARM), .SEED(SEED_V), .ERR_PERIOD(EP)) dut (
    .arr_stim_clk_ip(clk), .arr_stim_rst_n_ip(rst_n), .arr_stim_start_ip(start),
    .arr_stim_hold_ip(hold), .arr_stim_sig0_op(sig0), .arr_stim_sig1_op(sig1),
    .arr_stim_valid_op(valid), .arr_stim_busy_op(busy), .arr_stim_done_op(done),
    .arr_stim_vec_cnt_op(vec_cnt), .arr_stim_inj_cnt_op(inj_cnt)
  );

  arr_stim #(.LENGTH(LEN), .CYCLES(0), .WARMUP(WARM), .SEED(SEED_V), .ERR_PERIOD(EP)) dut_z (
    .arr_stim_clk_ip(clk), .arr_stim_rst_n_ip(rst_n), .arr_stim_start_ip(start),
    .arr_stim_hold_ip(hold), .arr_stim_sig0_op(sig0_z), .arr_stim_sig1_op(sig1_z),
    .arr_stim_valid_op(valid_z), .arr_stim_busy_op(busy_z), .arr_stim_done_op(done_z),
    .arr_stim_vec_cnt_op(vec_cnt_z), .arr_stim_inj_cnt_op(inj_cnt_z)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [LEN-1:0] s0;
    logic [LEN-1:0] s1;
    logic [31:0]    vc;
    logic [31:0]    ic;
  } exp_t;

  exp_t           q[$];
  logic [LEN-1:0] last_s0;
  logic [31:0]    last_ic;
  logic [LEN-1:0] first_s0;
  int             vcount;
  int             vz_count;

  function automatic logic [31:0] model_next(input logic [31:0] l);
    logic [31:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  // Queue the full expected vector sequence of one run.
  task automatic push_run();
    logic [31:0] l;
    logic [31:0] ic;
    exp_t        e;
    l  = SEED_V;
    ic = 0;
    for (int k = 1; k <= int'(CYC); k++) begin
      l    = model_next(l);
      e.s0 = l[LEN-1:0];
      e.s1 = e.s0;
`ifdef EXM_ARR_STIM_INJECT_EN
      if ((k % EP) == 0) begin
        e.s1 = e.s0 ^ 8'h01;
        ic++;
      end
`endif
      e.vc = 32'(k);
      e.ic = ic;
      q.push_back(e);
      last_s0 = e.s0;
      last_ic = ic;
    end
  endtask

  // Scoreboard: one expected entry per presented vector.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      vcount++;
      if (vcount == 1) first_s0 = sig0;
      if (q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("sig0", 64'(sig0), 64'(e.s0));
        check("sig1", 64'(sig1), 64'(e.s1));
        check("vec_cnt", 64'(vec_cnt), 64'(e.vc));
        check("inj_cnt", 64'(inj_cnt), 64'(e.ic));
      end
    end
    if (rst_n && valid_z) vz_count++;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // One run, edges counted from the start edge. hold_at/start_at = 0 disables.
  task automatic run(input int hold_at, input int start_at,
                     output int t_first, output int t_done, output int t_done_z);
    logic [LEN-1:0] held;
    logic [31:0]    held_cnt;
    held = '0;
    held_cnt = '0;
    t_first = -1; t_done = -1; t_done_z = -1;
    vcount = 0;
    push_run();
    pulse_start();
    @(negedge clk);
    check("start_busy", 64'(busy), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_vec_cnt", 64'(vec_cnt), 64'd0);
    check("start_inj_cnt", 64'(inj_cnt), 64'd0);
    for (int n = 1; n <= 40 && t_done < 0; n++) begin
      @(posedge clk); #1;
      if (n == hold_at)     hold = 1'b1;
      if (n == hold_at + 3) hold = 1'b0;
      if (n == start_at)     start = 1'b1;
      if (n == start_at + 1) start = 1'b0;
      @(negedge clk);
      if (valid && t_first < 0)  t_first = n;
      if (done && t_done < 0)    t_done = n;
      if (done_z && t_done_z < 0) t_done_z = n;
      if (n == hold_at) begin
        held = sig0;
        held_cnt = vec_cnt;
      end
      if (hold_at > 0 && n > hold_at && n <= hold_at + 3) begin
        check("hold_sig0", 64'(sig0), 64'(held));
        check("hold_vec_cnt", 64'(vec_cnt), 64'(held_cnt));
        check("hold_valid", 64'(valid), 64'd0);
      end
    end
    hold = 1'b0;
    start = 1'b0;
    if (t_done < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int tf, td, tdz;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sig0", 64'(sig0), 64'd0);
    check("rst_sig1", 64'(sig1), 64'd0);
    check("rst_vec_cnt", 64'(vec_cnt), 64'd0);
    check("rst_inj_cnt", 64'(inj_cnt), 64'd0);
    rst_n = 1'b1;

    // Run 1 from IDLE
    vz_count = 0;
    run(0, 0, tf, td, tdz);
    check("first_valid_edge", 64'(tf), 64'(WARM + 1));
    check("first_vec", 64'(first_s0), 64'h03);
    check("done_edge", 64'(td), 64'(WARM + CYC + 1));
    check("valid_cycles", 64'(vcount), 64'(CYC));
    check("end_vec_cnt", 64'(vec_cnt), 64'(CYC));
    check("end_inj_cnt", 64'(inj_cnt), 64'(last_ic));
    check("end_sig0", 64'(sig0), 64'(last_s0));
    check("end_busy", 64'(busy), 64'd0);
    check("end_valid", 64'(valid), 64'd0);
    check("sb_empty", 64'(q.size()), 64'd0);
    check("zero_done_edge", 64'(tdz), 64'(WARM));
    check("zero_vec_cnt", 64'(vec_cnt_z), 64'd0);
    check("zero_valid_cycles", 64'(vz_count), 64'd0);

    // Run 2: restart from DONE, with a start pulse mid-DRIVE that must be ignored
    run(0, 7, tf, td, tdz);
    check("restart_first_edge", 64'(tf), 64'(WARM + 1));
    check("restart_done_edge", 64'(td), 64'(WARM + CYC + 1));
    check("restart_valid_cycles", 64'(vcount), 64'(CYC));
    check("restart_sb_empty", 64'(q.size()), 64'd0);

    // Run 3: hold for 3 cycles mid-run
    run(7, 0, tf, td, tdz);
    check("hold_done_edge", 64'(td), 64'(WARM + CYC + 1 + 3));
    check("hold_valid_cycles", 64'(vcount), 64'(CYC));
    check("hold_end_vec_cnt", 64'(vec_cnt), 64'(CYC));
    check("hold_sb_empty", 64'(q.size()), 64'd0);

    // Run 4: asynchronous reset mid-DRIVE, checked before any clock edge
    vcount = 0;
    push_run();
    pulse_start();
    repeat (WARM + 5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_vec_cnt", 64'(vec_cnt), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_sig0", 64'(sig0), 64'd0);
    check("async_rst_sig1", 64'(sig1), 64'd0);
    check("async_rst_vec_cnt", 64'(vec_cnt), 64'd0);
    check("async_rst_inj_cnt", 64'(inj_cnt), 64'd0);
    q.delete();
    @(posedge clk); #1;
    check("rst_held_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
